mem_req_arb: RTL and testbench

MEM_REQ_ARB -- requirements
Module: mem_req_arb

---
 rtl/mem_req_arb.sv | 134 +++++++++++++
 tb/tb_mem_req_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arb.sv
// mem_req_arb: round-robin arbiter handing one memory port to NUM_REQ
// weight loaders. A grant is held while the owner keeps req high; after
// MAX_BEATS forwarded beats it is rotated away only if someone else waits.
// Beats are forwarded combinationally to the current owner.
//
// Optional build macro MEM_ARB_STATS_EN adds a saturating drop_cnt output
// counting mem_ready beats that arrive while no grant is active.
module mem_req_arb #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic                    mem_ready,
  input  logic [7:0][63:0]        mem_data,
  output logic                    mem_req,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      beat_valid,
  output logic [7:0][63:0]        beat_data,
  output logic                    busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             in_grant;
  logic             fwd;
  logic             own_req;
  logic             others_req;
  logic             rotate;

  assign in_grant   = (state == GRANT);
  assign fwd        = in_grant & mem_ready;
  assign own_req    = |(req & grant);
  assign others_req = |(req & ~grant);
  assign busy       = (state != IDLE);
  assign beat_data  = mem_data;

  // Per-requester beat strobe; grant is zero outside GRANT and under reset.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bv
    assign beat_valid[g] = grant[g] & fwd;
  end

  // Round-robin search starting just after the last released owner.
  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(last_grant) + 1 + i) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Beat count including this cycle's beat, saturating at MAX_BEATS, so the
  // MAX_BEATS-th beat itself closes a contended grant (exactly MAX_BEATS beats).
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    if (fwd && (beat_cnt != CNT_W'(MAX_BEATS)))
      beat_cnt_nxt = beat_cnt + CNT_W'(1);
  end

  assign rotate = (beat_cnt_nxt == CNT_W'(MAX_BEATS)) & others_req;

  // Arbitration FSM with registered grant / mem_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      mem_req    <= 1'b0;
      beat_cnt   <= '0;
      gnt_idx    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            grant    <= NUM_REQ'(1) << win_idx;
            gnt_idx  <= win_idx;
            mem_req  <= 1'b1;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          beat_cnt <= beat_cnt_nxt;
          if (!own_req || rotate) begin
            state   <= RELEASE;
            grant   <= '0;
            mem_req <= 1'b0;
          end
        end
        RELEASE: begin
          last_grant <= gnt_idx;
          state      <= IDLE;
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Count beats that arrive with no owner to take them, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (mem_ready && !in_grant && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb (NUM_REQ=3, MAX_BEATS=16).
// Inputs change 1ns after posedge; outputs are sampled 2ns after posedge.
module tb_mem_req_arb;
  localparam int NR = 3;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic            mem_ready = 1'b0;
  logic [7:0][63:0] mem_data = '0;
  logic            mem_req;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   beat_valid;
  logic [7:0][63:0] beat_data;
  logic            busy;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]     drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_arb #(.NUM_REQ(NR), .MAX_BEATS(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .mem_req    (mem_req),
    .grant      (grant),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .busy       (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    mem_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_data(input int k);
    for (int l = 0; l < 8; l++) mem_data[l] = {32'hA5A5_0000 + 32'(k), 32'(l)};
  endtask

  task automatic chk_data(input string tag, input int k);
    for (int l = 0; l < 8; l++)
      chk($sformatf("%s_lane%0d", tag, l), beat_data[l], {32'hA5A5_0000 + 32'(k), 32'(l)});
  endtask

  initial begin
    int n, held, bad;
    logic [NR-1:0] prev;
    logic [NR-1:0] seq[$];
    int beats[$];

    // Reset state
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bv", beat_valid, 0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_drop", drop_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // A: single requester, 4 beats, release, idle
    req = 3'b001;
    #1; chk("a_lat_grant0", grant, 0);
    step();
    chk("a_grant", grant, 3'b001);
    chk("a_mem_req", mem_req, 1);
    chk("a_busy", busy, 1);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      set_data(k);
      #1;
      if (beat_valid === 3'b001) n++;
      if (k == 2) chk_data("a_data", 2);
      step();
    end
    chk("a_beats", n, 4);
    mem_ready = 1'b0;
    req = 3'b000;
    #1;
    chk("a_bv_nordy", beat_valid, 0);
    chk("a_grant_last", grant, 3'b001);
    step();
    chk("a_rel_grant", grant, 0);
    chk("a_rel_mem_req", mem_req, 0);
    chk("a_rel_busy", busy, 1);
    step();
    chk("a_idle_busy", busy, 0);

    // B: lone requester 1 streams 40 beats, grant never rotates
    req = 3'b010;
    step();
    chk("b_grant", grant, 3'b010);
    n = 0; held = 0;
    mem_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (beat_valid === 3'b010) n++;
      if (grant === 3'b010) held++;
      step();
    end
    chk("b_beats", n, 40);
    chk("b_held", held, 40);
    chk("b_cnt_sat", dut.beat_cnt, MB);
    chk("b_still_grant", grant, 3'b010);
    // saturated counter + new requester -> rotate, wrap to requester 0
    req = 3'b011;
    mem_ready = 1'b0;
    step();
    chk("b_rot_grant", grant, 0);
    chk("b_rot_busy", busy, 1);
    step();
    chk("b_rot_idle", busy, 0);
    step();
    chk("b_rot_wrap", grant, 3'b001);
    req = 3'b000;
    step();
    step();

    // C: all three requesting, continuous beats
    do_reset();
    req = 3'b111;
    mem_ready = 1'b1;
    prev = '0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (grant != 0 && prev == 0) begin
        seq.push_back(grant);
        beats.push_back(0);
      end
      if (beat_valid != 0 && beats.size() > 0) beats[beats.size()-1]++;
      if (beat_valid != 0 && beat_valid !== grant) bad++;
      if (grant == 0 && (mem_req || beat_valid != 0)) bad++;
      if ($countones(grant) > 1) bad++;
      prev = grant;
      step();
    end
    chk("c_ngrants", seq.size(), 4);
    if (seq.size() == 4) begin
      chk("c_seq0", seq[0], 3'b001);
      chk("c_seq1", seq[1], 3'b010);
      chk("c_seq2", seq[2], 3'b100);
      chk("c_seq3", seq[3], 3'b001);
      chk("c_beats0", beats[0], MB);
      chk("c_beats1", beats[1], MB);
      chk("c_beats2", beats[2], MB);
    end
    chk("c_violations", bad, 0);
    req = 3'b000;
    mem_ready = 1'b0;
    step();
    step();
    chk("c_end_busy", busy, 0);

    // D: beat in the same cycle req drops is still forwarded
    do_reset();
    req = 3'b001;
    step();
    chk("d_grant", grant, 3'b001);
    req = 3'b000;
    mem_ready = 1'b1;
    set_data(7);
    #1;
    chk("d_bv", beat_valid, 3'b001);
    chk_data("d_data", 7);
    step();
    chk("d_grant_off", grant, 0);
    chk("d_rel_bv", beat_valid, 0);
    chk("d_rel_busy", busy, 1);
    mem_ready = 1'b0;
    step();
    chk("d_idle", busy, 0);

    // E: async reset mid-GRANT, then requester 1 wins
    req = 3'b100;
    step();
    chk("e_grant", grant, 3'b100);
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_rst_grant", grant, 0);
    chk("e_rst_mem_req", mem_req, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_bv", beat_valid, 0);
    #1;
    rst_n = 1'b1;
    req = 3'b110;
    mem_ready = 1'b0;
    step();
    chk("e_grant2", grant, 3'b010);
    req = 3'b000;
    step();
    step();

    // F: mem_ready while idle is dropped
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      #1;
      chk($sformatf("f_bv%0d", k), beat_valid, 0);
      step();
      mem_ready = 1'b0;
      step();
    end
    chk("f_busy", busy, 0);
`ifdef MEM_ARB_STATS_EN
    chk("f_drop", drop_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
